elevator_dispatch_ctrl: RTL and testbench

//  Call scheduler for a single elevator car. Latches floor call pulses into a pending set,

---
 rtl/elevator_dispatch_ctrl.sv | 143 ++++++++++++++
 tb/tb_elevator_dispatch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/elevator_dispatch_ctrl.sv
// SCAN call scheduler for a single elevator car: latches calls, tracks the car floor,
// chooses the travel direction and sequences motor, door dwell and emergency handling.
module elevator_dispatch_ctrl #(
    parameter int NUM_FLOORS  = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [NUM_FLOORS-1:0] floor_sensor,
    input  logic                  emergency_stop,
    input  logic                  clear_emergency,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  alarm,
    output logic                  busy,
    output logic [FW-1:0]         current_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR,
        S_EMERG
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [CW-1:0]         door_cnt_q, door_cnt_d;

    logic [NUM_FLOORS-1:0] eff;
    logic [NUM_FLOORS-1:0] call_mask;
    logic                  above, below, here;
    logic                  sensor_valid;
    logic [FW-1:0]         sensor_idx;

    always_comb begin
        eff          = pending_q | call_req;
        above        = 1'b0;
        below        = 1'b0;
        sensor_idx   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (eff[i] && (i > int'(floor_q))) above = 1'b1;
            if (eff[i] && (i < int'(floor_q))) below = 1'b1;
            if (floor_sensor[i]) sensor_idx = FW'(i);
        end
        here         = eff[floor_q];
        sensor_valid = $onehot(floor_sensor);
        // A button at the open-door floor extends the dwell instead of queueing a revisit.
        call_mask    = call_req;
        if (state_q == S_DOOR) call_mask[floor_q] = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | call_mask;
        floor_d    = sensor_valid ? sensor_idx : floor_q;
        dir_up_d   = dir_up_q;
        door_cnt_d = door_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d            = S_DOOR;
                    pending_d[floor_q] = 1'b0;
                    door_cnt_d         = DOOR_LOAD;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = S_MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = S_MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (sensor_valid) begin
                    if (eff[sensor_idx]) begin
                        state_d               = S_DOOR;
                        pending_d[sensor_idx] = 1'b0;
                        door_cnt_d            = DOOR_LOAD;
                    end else if ((state_q == S_MOVE_UP   && sensor_idx == TOP_FLOOR) ||
                                 (state_q == S_MOVE_DOWN && sensor_idx == '0)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                if (call_req[floor_q]) begin
                    door_cnt_d = DOOR_LOAD;
                end else if (door_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    door_cnt_d = door_cnt_q - CW'(1);
                end
            end
            S_EMERG: begin
                pending_d = pending_q;
                if (clear_emergency && !emergency_stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (emergency_stop) begin
            state_d   = S_EMERG;
            pending_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            floor_q    <= '0;
            dir_up_q   <= 1'b1;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            floor_q    <= floor_d;
            dir_up_q   <= dir_up_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign motor_up      = (state_q == S_MOVE_UP);
    assign motor_down    = (state_q == S_MOVE_DOWN);
    assign door_open     = (state_q == S_DOOR);
    assign alarm         = (state_q == S_EMERG);
    assign busy          = (state_q != S_IDLE);
    assign current_floor = floor_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_dispatch_ctrl.sv
// Directed bench for elevator_dispatch_ctrl: each driven cycle queues a hand-computed
// expected output snapshot that the monitor compares one cycle-sample later.
module tb_elevator_dispatch_ctrl;

    localparam int ST_I = 0;
    localparam int ST_U = 1;
    localparam int ST_D = 2;
    localparam int ST_O = 3;
    localparam int ST_E = 4;

    logic       clk;
    logic       rst;
    logic [3:0] call_req;
    logic [3:0] floor_sensor;
    logic       emergency_stop;
    logic       clear_emergency;
    logic       motor_up, motor_down, door_open, alarm, busy;
    logic [1:0] current_floor;
    logic [3:0] pending;

    logic [10:0] exp_q[$];
    string       tag_q[$];
    string       cur_tag;
    int          checks;
    int          failures;
    bit          driver_done;

    elevator_dispatch_ctrl #(.NUM_FLOORS(4), .DOOR_CYCLES(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .call_req        (call_req),
        .floor_sensor    (floor_sensor),
        .emergency_stop  (emergency_stop),
        .clear_emergency (clear_emergency),
        .motor_up        (motor_up),
        .motor_down      (motor_down),
        .door_open       (door_open),
        .alarm           (alarm),
        .busy            (busy),
        .current_floor   (current_floor),
        .pending         (pending)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] pack(input int st, input logic [1:0] cf, input logic [3:0] p);
        pack = {st == ST_U, st == ST_D, st == ST_O, st == ST_E, st != ST_I, cf, p};
    endfunction

    // driver tasks
    task automatic step(input logic r, input logic [3:0] call, input logic [3:0] sens,
                        input logic es, input logic clr,
                        input int st, input logic [1:0] cf, input logic [3:0] p);
        @(negedge clk);
        rst             = r;
        call_req        = call;
        floor_sensor    = sens;
        emergency_stop  = es;
        clear_emergency = clr;
        exp_q.push_back(pack(st, cf, p));
        tag_q.push_back(cur_tag);
    endtask

    task automatic hold(input int n, input int st, input logic [1:0] cf, input logic [3:0] p);
        for (int k = 0; k < n; k++) step(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, st, cf, p);
    endtask

    // scoreboard monitor: one snapshot per cycle, sampled 2ns after the rising edge
    initial begin
        logic [10:0] got, want;
        string       tag;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                tag  = tag_q.pop_front();
                got  = {motor_up, motor_down, door_open, alarm, busy, current_floor, pending};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s: actual=%b required=%b (up,down,door,alarm,busy,floor[1:0],pending[3:0])",
                             tag, got, want);
                end
            end
        end
    end

    initial begin
        checks          = 0;
        failures        = 0;
        driver_done     = 1'b0;
        rst             = 1'b1;
        call_req        = '0;
        floor_sensor    = '0;
        emergency_stop  = 1'b0;
        clear_emergency = 1'b0;

        cur_tag = "reset";
        step(1, 4'b0000, 4'b0000, 0, 0, ST_I, 2'd0, 4'b0000);

        cur_tag = "t1_call_up";
        step(0, 4'b0100, 4'b0000, 0, 0, ST_U, 2'd0, 4'b0100);
        step(0, 4'b0000, 4'b0010, 0, 0, ST_U, 2'd1, 4'b0100);
        step(0, 4'b0000, 4'b0100, 0, 0, ST_O, 2'd2, 4'b0000);
        cur_tag = "t1_door_dwell";
        hold(7, ST_O, 2'd2, 4'b0000);
        hold(1, ST_I, 2'd2, 4'b0000);

        cur_tag = "t3_door_extend";
        step(0, 4'b0100, 4'b0000, 0, 0, ST_O, 2'd2, 4'b0000);
        hold(4, ST_O, 2'd2, 4'b0000);
        step(0, 4'b0100, 4'b0000, 0, 0, ST_O, 2'd2, 4'b0000);
        hold(7, ST_O, 2'd2, 4'b0000);
        hold(1, ST_I, 2'd2, 4'b0000);

        cur_tag = "t2_setup";
        step(1, 4'b0000, 4'b0000, 0, 0, ST_I, 2'd0, 4'b0000);
        step(0, 4'b0010, 4'b0000, 0, 0, ST_U, 2'd0, 4'b0010);
        step(0, 4'b0000, 4'b0010, 0, 0, ST_O, 2'd1, 4'b0000);
        hold(7, ST_O, 2'd1, 4'b0000);
        hold(1, ST_I, 2'd1, 4'b0000);

        cur_tag = "t2_scan_up";
        step(0, 4'b1001, 4'b0000, 0, 0, ST_U, 2'd1, 4'b1001);
        cur_tag = "t5_bad_sensor";
        step(0, 4'b0000, 4'b0110, 0, 0, ST_U, 2'd1, 4'b1001);
        step(0, 4'b0000, 4'b0000, 0, 0, ST_U, 2'd1, 4'b1001);
        cur_tag = "t2_pass_through";
        step(0, 4'b0000, 4'b0100, 0, 0, ST_U, 2'd2, 4'b1001);
        step(0, 4'b0000, 4'b1000, 0, 0, ST_O, 2'd3, 4'b0001);
        hold(7, ST_O, 2'd3, 4'b0001);
        hold(1, ST_I, 2'd3, 4'b0001);
        cur_tag = "t2_scan_down";
        hold(1, ST_D, 2'd3, 4'b0001);
        step(0, 4'b0000, 4'b0100, 0, 0, ST_D, 2'd2, 4'b0001);
        step(0, 4'b0000, 4'b0010, 0, 0, ST_D, 2'd1, 4'b0001);
        step(0, 4'b0000, 4'b0001, 0, 0, ST_O, 2'd0, 4'b0000);
        hold(7, ST_O, 2'd0, 4'b0000);
        hold(1, ST_I, 2'd0, 4'b0000);

        cur_tag = "end_floor_idle";
        step(0, 4'b0100, 4'b0000, 0, 0, ST_U, 2'd0, 4'b0100);
        step(0, 4'b0000, 4'b1000, 0, 0, ST_I, 2'd3, 4'b0100);
        hold(1, ST_D, 2'd3, 4'b0100);
        step(0, 4'b0000, 4'b0100, 0, 0, ST_O, 2'd2, 4'b0000);
        hold(7, ST_O, 2'd2, 4'b0000);
        hold(1, ST_I, 2'd2, 4'b0000);

        cur_tag = "arrive_with_call";
        step(0, 4'b0001, 4'b0000, 0, 0, ST_D, 2'd2, 4'b0001);
        step(0, 4'b0010, 4'b0010, 0, 0, ST_O, 2'd1, 4'b0001);
        hold(7, ST_O, 2'd1, 4'b0001);
        hold(1, ST_I, 2'd1, 4'b0001);
        hold(1, ST_D, 2'd1, 4'b0001);
        step(0, 4'b0000, 4'b0001, 0, 0, ST_O, 2'd0, 4'b0000);
        hold(7, ST_O, 2'd0, 4'b0000);
        hold(1, ST_I, 2'd0, 4'b0000);

        cur_tag = "t4_emergency";
        step(0, 4'b0100, 4'b0000, 0, 0, ST_U, 2'd0, 4'b0100);
        step(0, 4'b0010, 4'b0000, 1, 0, ST_E, 2'd0, 4'b0000);
        step(0, 4'b1000, 4'b0010, 1, 0, ST_E, 2'd1, 4'b0000);
        step(0, 4'b0000, 4'b0000, 1, 1, ST_E, 2'd1, 4'b0000);
        step(0, 4'b0001, 4'b0000, 0, 0, ST_E, 2'd1, 4'b0000);
        step(0, 4'b0000, 4'b0000, 0, 1, ST_I, 2'd1, 4'b0000);
        hold(1, ST_I, 2'd1, 4'b0000);

        cur_tag = "t6_reset_mid_move";
        step(0, 4'b1000, 4'b0000, 0, 0, ST_U, 2'd1, 4'b1000);
        step(0, 4'b0000, 4'b1000, 0, 0, ST_O, 2'd3, 4'b0000);
        hold(7, ST_O, 2'd3, 4'b0000);
        hold(1, ST_I, 2'd3, 4'b0000);
        step(0, 4'b0011, 4'b0000, 0, 0, ST_D, 2'd3, 4'b0011);
        step(0, 4'b0000, 4'b0100, 0, 0, ST_D, 2'd2, 4'b0011);
        step(1, 4'b0000, 4'b0000, 0, 0, ST_I, 2'd0, 4'b0000);
        cur_tag = "rst_beats_estop";
        step(1, 4'b0100, 4'b0000, 1, 0, ST_I, 2'd0, 4'b0000);
        hold(1, ST_I, 2'd0, 4'b0000);

        driver_done = 1'b1;
    end

    // final report
    initial begin
        wait (driver_done);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual=%0d_left required=0_left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
